// File: rtl/uart_show_tx_if.sv
// Handshake bundle between the display logic and the serial transmitter:
// request/buffer/length in one direction, busy/done status back.
interface uart_show_tx_if;
   logic         start;
   logic [127:0] tx_show;
   logic [4:0]   show_len;
   logic         busy;
   logic         done;

   modport master (output start, tx_show, show_len, input busy, done);
   modport slave  (input start, tx_show, show_len, output busy, done);
endinterface

// File: rtl/uart_show_tx.sv
// UART 8N1 transmitter for the debug link: sends up to 16 bytes of a packed buffer,
// highest valid byte first. Define UART_SHOW_TX_PARITY_EN to add an even-parity bit.
module uart_show_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic          clk,
   input  logic          reset,
   uart_show_tx_if.slave bus,
   output logic          tx
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_SHOW_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t       state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]   bit_q, bit_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [127:0] buf_q, buf_d;
   logic         tx_q, tx_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [4:0]   n_clamp;
   logic [7:0]   shamt;
   logic [7:0]   cur_byte;

   // The byte on the wire is always the top byte of the buffer; the buffer is
   // left-aligned at accept so byte N-1 lands there first.
   assign cur_byte = buf_q[127:120];

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      n_clamp = (bus.show_len > 5'd16) ? 5'd16 : bus.show_len;
      shamt   = {5'd16 - n_clamp, 3'b000};

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (bus.start) begin
               buf_d = bus.tx_show << shamt;
               cnt_d = n_clamp;
               if (n_clamp == 5'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = START;
                  tx_d    = 1'b0;
                  busy_d  = 1'b1;
                  baud_d  = BIT_LAST;
               end
            end
         end
         START: begin
            if (baud_q == '0) begin
               state_d = DATA;
               tx_d    = cur_byte[0];
               bit_d   = 3'd0;
               baud_d  = BIT_LAST;
            end else begin
               baud_d = baud_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (baud_q == '0) begin
               baud_d = BIT_LAST;
               if (bit_q == 3'd7) begin
`ifdef UART_SHOW_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^cur_byte;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = cur_byte[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q - CNT_W'(1);
            end
         end
`ifdef UART_SHOW_TX_PARITY_EN
         PARITY: begin
            if (baud_q == '0) begin
               state_d = STOP;
               tx_d    = 1'b1;
               baud_d  = BIT_LAST;
            end else begin
               baud_d = baud_q - CNT_W'(1);
            end
         end
`endif
         STOP: begin
            if (baud_q == '0) begin
               cnt_d = cnt_q - 5'd1;
               buf_d = buf_q << 8;
               if (cnt_q != 5'd1) begin
                  // Next start bit follows the stop bit with no idle gap.
                  state_d = START;
                  tx_d    = 1'b0;
                  baud_d  = BIT_LAST;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  baud_d  = '0;
               end
            end else begin
               baud_d = baud_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Payload storage carries no reset; it is reloaded on every accept.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign tx       = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_uart_show_tx.sv
// Scoreboard bench for uart_show_tx at CLKS_PER_BIT=4; a line decoder and a
// status monitor pop expectations pushed by the directed stimulus.
module tb_uart_show_tx;
   localparam int CPB = 4;
`ifdef UART_SHOW_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int F = CPB * (10 + PB);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx;
   uart_show_tx_if bus();

   uart_show_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_vec = 0;
   int n_fail = 0;
   int busy_from = 1;
   int busy_to = 0;
   logic [8:0] exp_bytes[$];
   int exp_done[$];

   bit         mon_act = 1'b0;
   int         mon_off = 0;
   logic [7:0] mon_byte;
   logic       mon_par;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Line decoder: samples each bit two cycles into its CPB-cycle slot.
   initial forever begin
      int idx;
      logic [8:0] e;
      @(negedge clk);
      if (reset !== 1'b0) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act  = 1'b1;
            mon_off  = 0;
            mon_byte = 8'h00;
            mon_par  = 1'b0;
         end
      end else begin
         mon_off++;
         if (mon_off >= 2 && (mon_off - 2) % CPB == 0) begin
            idx = (mon_off - 2) / CPB;
            if (idx == 0) begin
               chk("start_bit", {31'd0, tx}, 32'd0);
            end else if (idx <= 8) begin
               mon_byte[idx-1] = tx;
            end else if (PB == 1 && idx == 9) begin
               mon_par = tx;
            end else begin
               chk("stop_bit", {31'd0, tx}, 32'd1);
               if (exp_bytes.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL byte_extra: got %h, expected none (cycle %0d)", mon_byte, cyc);
               end else begin
                  e = exp_bytes.pop_front();
                  chk("byte", {23'd0, mon_par, mon_byte}, {23'd0, e});
               end
               mon_act = 1'b0;
            end
         end
      end
   end

   // Status monitor: busy window, idle line level and done timing.
   initial forever begin
      logic eb;
      int d;
      @(negedge clk);
      if (reset === 1'b0) begin
         eb = (cyc >= busy_from) && (cyc <= busy_to);
         chk("busy", {31'd0, bus.busy}, {31'd0, eb});
         if (!eb) chk("tx_idle", {31'd0, tx}, 32'd1);
         if (bus.done !== 1'b0) begin
            if (exp_done.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL done_extra: got done=%b, expected 0 (cycle %0d)", bus.done, cyc);
            end else begin
               d = exp_done.pop_front();
               chk("done_cycle", cyc, d);
            end
         end
      end
   end

   task automatic push_bytes(input logic [127:0] data, input int n);
      logic [7:0] b;
      logic p;
      for (int k = n - 1; k >= 0; k--) begin
         b = data[8*k +: 8];
         p = (PB == 1) ? ^b : 1'b0;
         exp_bytes.push_back({p, b});
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_txn(input logic [127:0] data, input logic [4:0] len,
                            input bit push, output int t, output int n);
      @(posedge clk);
      #1;
      bus.tx_show  = data;
      bus.show_len = len;
      bus.start    = 1'b1;
      t = cyc;
      n = (len > 5'd16) ? 16 : int'(len);
      if (push) begin
         push_bytes(data, n);
         exp_done.push_back(t + 1 + n * F);
      end
      if (n > 0) begin
         busy_from = t + 1;
         busy_to   = t + n * F;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int n);
      bit got;
      got = 1'b0;
      for (int i = 0; i < n * F + 8 && !got; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) got = 1'b1;
      end
      if (!got) begin
         n_vec++;
         n_fail++;
         $display("FAIL done_timeout: got no done, expected done within %0d cycles", n * F + 8);
      end
   endtask

   task automatic send(input logic [127:0] data, input logic [4:0] len);
      int t, n;
      start_txn(data, len, 1'b1, t, n);
      wait_done(n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "simulation timeout");
   end

   initial begin
      int t, n;
      bus.start    = 1'b0;
      bus.tx_show  = '0;
      bus.show_len = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);

      // Single byte 0x55: alternating line, done at T+41.
      send(128'h55, 5'd1);
      // Multi-byte order: 0x0A, 0x0B, 0x0C back-to-back, done at T+121.
      send(128'h0A0B0C, 5'd3);
      // Zero length: done at T+1, line stays high.
      send(128'hDEAD, 5'd0);
      // Clamp: length 20 sends all 16 bytes, done at T+641.
      send(128'hFFEEDDCCBBAA99887766554433221100, 5'd20);

      // Start while busy is ignored; inputs changing mid-send have no effect;
      // start held through the done cycle launches the next frame.
      start_txn(128'h1234, 5'd2, 1'b1, t, n);
      wait_cyc(t + 10);
      bus.tx_show  = {128{1'b1}};
      bus.show_len = 5'd5;
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_cyc(t + 79);
      bus.tx_show  = 128'hC3;
      bus.show_len = 5'd1;
      bus.start    = 1'b1;
      wait_cyc(t + 81);
      push_bytes(128'hC3, 1);
      exp_done.push_back(t + 81 + 1 + F);
      busy_from = t + 82;
      busy_to   = t + 81 + F;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(1);

      // Reset during bit 3 of byte 0 abandons the frame.
      start_txn(128'h5A, 5'd1, 1'b0, t, n);
      wait_cyc(t + 14);
      reset   = 1'b1;
      busy_to = t + 14;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("midrst_tx", {31'd0, tx}, 32'd1);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(128'hA5, 5'd1);

`ifdef UART_SHOW_TX_PARITY_EN
      // Even parity: 0x07 -> 1, 0x03 -> 0; done at T+45.
      send(128'h07, 5'd1);
      send(128'h03, 5'd1);
`endif

      repeat (10) @(posedge clk);
      #1;
      chk("bytes_left", exp_bytes.size(), 32'd0);
      chk("dones_left", exp_done.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
